// File: rtl/z80_mem_bridge_if.sv
// Bus bundle between a Z80 core and the memory / I/O handshakes of z80_mem_bridge.
// The master modport is the bridge itself; slave is the CPU-plus-memory side.
interface z80_mem_bridge_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_m1_n;
    logic        cpu_mreq_n;
    logic        cpu_iorq_n;
    logic        cpu_rd_n;
    logic        cpu_wr_n;
    logic [7:0]  cpu_di;
    logic        cpu_wait_n;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        io_req;
    logic        io_we;
    logic [7:0]  io_addr;
    logic [7:0]  io_wdata;
    logic        io_ack;
    logic [7:0]  io_rdata;

    modport master (
        input  cpu_a, cpu_dout, cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
        input  mem_ack, mem_rdata, io_ack, io_rdata,
        output cpu_di, cpu_wait_n,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output io_req, io_we, io_addr, io_wdata
    );

    modport slave (
        output cpu_a, cpu_dout, cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
        output mem_ack, mem_rdata, io_ack, io_rdata,
        input  cpu_di, cpu_wait_n,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  io_req, io_we, io_addr, io_wdata
    );
endinterface

// File: rtl/z80_mem_bridge.sv
// Converts Z80 bus cycles into single req/ack transactions, stretching the CPU with WAIT.
// Define Z80_MEM_BRIDGE_IOPORT_EN to service I/O cycles on the io_* handshake.
module z80_mem_bridge #(
    parameter logic [7:0] INTACK_VECTOR = 8'hFF,
    parameter logic [7:0] IDLE_DATA     = 8'hFF
) (
    input  logic             clk,
    input  logic             reset,
    z80_mem_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, MEM, IO, HOLD} state_t;

    state_t      state_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [15:0] mem_addr_reg;
    logic [7:0]  mem_wdata_reg;
    logic [7:0]  cpu_di_reg;
    logic        wait_n;

    logic strobe;
    logic mem_access;
    logic io_access;
    logic intack;
    logic io_stall;

    // Memory decode takes priority so an illegal mixed MREQ/IORQ cycle is a memory cycle.
    assign strobe     = ~bus.cpu_rd_n | ~bus.cpu_wr_n;
    assign mem_access = ~bus.cpu_mreq_n & strobe;
    assign io_access  = ~bus.cpu_iorq_n & bus.cpu_m1_n & strobe & ~mem_access;
    assign intack     = ~bus.cpu_iorq_n & ~bus.cpu_m1_n & ~mem_access;

`ifdef Z80_MEM_BRIDGE_IOPORT_EN
    logic       io_req_reg;
    logic       io_we_reg;
    logic [7:0] io_addr_reg;
    logic [7:0] io_wdata_reg;

    assign io_stall     = io_access;
    assign bus.io_req   = io_req_reg;
    assign bus.io_we    = io_we_reg;
    assign bus.io_addr  = io_addr_reg;
    assign bus.io_wdata = io_wdata_reg;
`else
    assign io_stall     = 1'b0;
    assign bus.io_req   = 1'b0;
    assign bus.io_we    = 1'b0;
    assign bus.io_addr  = 8'h00;
    assign bus.io_wdata = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 16'h0000;
            mem_wdata_reg <= 8'h00;
            cpu_di_reg    <= IDLE_DATA;
`ifdef Z80_MEM_BRIDGE_IOPORT_EN
            io_req_reg    <= 1'b0;
            io_we_reg     <= 1'b0;
            io_addr_reg   <= 8'h00;
            io_wdata_reg  <= 8'h00;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_access) begin
                        state_reg     <= MEM;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= ~bus.cpu_wr_n;
                        mem_addr_reg  <= bus.cpu_a;
                        mem_wdata_reg <= bus.cpu_dout;
                    end else if (io_access) begin
`ifdef Z80_MEM_BRIDGE_IOPORT_EN
                        state_reg    <= IO;
                        io_req_reg   <= 1'b1;
                        io_we_reg    <= ~bus.cpu_wr_n;
                        io_addr_reg  <= bus.cpu_a[7:0];
                        io_wdata_reg <= bus.cpu_dout;
`else
                        // No I/O target: reads float to the idle byte, writes are dropped.
                        state_reg <= HOLD;
                        if (!bus.cpu_rd_n) begin
                            cpu_di_reg <= IDLE_DATA;
                        end
`endif
                    end else if (intack) begin
                        state_reg  <= HOLD;
                        cpu_di_reg <= INTACK_VECTOR;
                    end
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        state_reg   <= HOLD;
                        mem_req_reg <= 1'b0;
                        if (!mem_we_reg) begin
                            cpu_di_reg <= bus.mem_rdata;
                        end
                    end
                end
                IO: begin
`ifdef Z80_MEM_BRIDGE_IOPORT_EN
                    if (bus.io_ack) begin
                        state_reg  <= HOLD;
                        io_req_reg <= 1'b0;
                        if (!io_we_reg) begin
                            cpu_di_reg <= bus.io_rdata;
                        end
                    end
`else
                    state_reg <= IDLE;
`endif
                end
                HOLD: begin
                    // Wait for the strobe to drop so a long strobe yields one request only.
                    if (bus.cpu_rd_n && bus.cpu_wr_n) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        wait_n = 1'b1;
        if (!reset) begin
            case (state_reg)
                IDLE:    wait_n = ~(mem_access | io_stall);
                MEM:     wait_n = 1'b0;
                IO:      wait_n = 1'b0;
                default: wait_n = 1'b1;
            endcase
        end
    end

    assign bus.cpu_wait_n = wait_n;
    assign bus.cpu_di     = cpu_di_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Randomized bench for z80_mem_bridge: drives Z80 bus cycles on negedge, answers requests
// with random latency, and compares against a transaction-level model of cpu_di and WAIT.
module tb_z80_mem_bridge;

    localparam logic [7:0] INTACK_VECTOR = 8'hE7;
    localparam logic [7:0] IDLE_DATA     = 8'hFF;
`ifdef Z80_MEM_BRIDGE_IOPORT_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    localparam int K_NONE = -1;
    localparam int K_MRD  = 0;
    localparam int K_MWR  = 1;
    localparam int K_IORD = 2;
    localparam int K_IOWR = 3;
    localparam int K_RFSH = 4;
    localparam int K_INTA = 5;
    localparam int K_BOTH = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z80_mem_bridge_if bus();

    z80_mem_bridge #(
        .INTACK_VECTOR(INTACK_VECTOR),
        .IDLE_DATA    (IDLE_DATA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] di_model;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_bus(input int kind, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_a      = a;
        bus.cpu_dout   = d;
        bus.cpu_m1_n   = 1'b1;
        bus.cpu_mreq_n = 1'b1;
        bus.cpu_iorq_n = 1'b1;
        bus.cpu_rd_n   = 1'b1;
        bus.cpu_wr_n   = 1'b1;
        case (kind)
            K_MRD:  begin bus.cpu_mreq_n = 1'b0; bus.cpu_rd_n = 1'b0; bus.cpu_m1_n = 1'($urandom_range(0, 1)); end
            K_MWR:  begin bus.cpu_mreq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
            K_IORD: begin bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
            K_IOWR: begin bus.cpu_iorq_n = 1'b0; bus.cpu_wr_n = 1'b0; end
            K_RFSH: begin bus.cpu_mreq_n = 1'b0; end
            K_INTA: begin bus.cpu_iorq_n = 1'b0; bus.cpu_m1_n = 1'b0; end
            K_BOTH: begin bus.cpu_mreq_n = 1'b0; bus.cpu_iorq_n = 1'b0; bus.cpu_rd_n = 1'b0; end
            default: ;
        endcase
    endtask

    // One full CPU cycle: strobe held for dly+6 cycles, ack raised dly cycles after the request appears.
    task automatic do_cycle(input int kind, input logic [15:0] a, input logic [7:0] d,
                            input int dly, input logic [7:0] rd_data, input string name);
        bit is_mem = (kind == K_MRD) || (kind == K_MWR) || (kind == K_BOTH);
        bit is_io  = (kind == K_IORD) || (kind == K_IOWR);
        int exp_wait = (is_mem || (is_io && IO_EN)) ? dly + 1 : 0;
        int wait_cnt = 0;
        int mem_rises = 0;
        int io_rises = 0;
        int seen = 0;
        int bad_hold = 0;
        logic prev_mem = 1'b0;
        logic prev_io = 1'b0;

        @(negedge clk);
        set_bus(kind, a, d);
        for (int c = 0; c < dly + 6; c++) begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.io_ack  = 1'b0;
            if (!bus.cpu_wait_n) wait_cnt++;
            if (bus.mem_req && !prev_mem) mem_rises++;
            if (bus.io_req && !prev_io) io_rises++;
            prev_mem = bus.mem_req;
            prev_io  = bus.io_req;
            if (bus.mem_req) begin
                if (bus.mem_addr !== a || bus.mem_we !== (kind == K_MWR) || bus.mem_wdata !== d) bad_hold++;
                if (seen == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd_data;
                end
                seen++;
            end else if (bus.io_req) begin
                if (bus.io_addr !== a[7:0] || bus.io_we !== (kind == K_IOWR) || bus.io_wdata !== d) bad_hold++;
                if (seen == dly) begin
                    bus.io_ack   = 1'b1;
                    bus.io_rdata = rd_data;
                end
                seen++;
            end else if ($urandom_range(0, 3) == 0) begin
                // Stray acks with no request outstanding must not disturb cpu_di.
                bus.mem_ack   = 1'b1;
                bus.io_ack    = 1'b1;
                bus.mem_rdata = 8'($urandom);
                bus.io_rdata  = 8'($urandom);
            end
        end

        if (kind == K_MRD || kind == K_BOTH) di_model = rd_data;
        if (kind == K_IORD) di_model = IO_EN ? rd_data : IDLE_DATA;
        if (kind == K_INTA) di_model = INTACK_VECTOR;

        check({name, ".wait_cycles"}, wait_cnt, exp_wait);
        check({name, ".mem_reqs"}, mem_rises, is_mem ? 1 : 0);
        check({name, ".io_reqs"}, io_rises, (is_io && IO_EN) ? 1 : 0);
        check({name, ".req_stable"}, bad_hold, 0);
        check({name, ".cpu_di"}, bus.cpu_di, di_model);

        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.io_ack  = 1'b0;
        set_bus(K_NONE, 16'h0000, 8'h00);
        @(negedge clk);
        check({name, ".idle_wait_n"}, bus.cpu_wait_n, 1);
        check({name, ".idle_di"}, bus.cpu_di, di_model);
        $display("[TB] %s kind=%0d a=%h d=%h dly=%0d wait=%0d di=%h", name, kind, a, d, dly, wait_cnt, bus.cpu_di);
    endtask

    task automatic reset_mid_req();
        @(negedge clk);
        set_bus(K_MRD, 16'h2468, 8'h00);
        @(negedge clk);
        check("rst.req_up", bus.mem_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst.req_drop", bus.mem_req, 0);
        check("rst.wait_n", bus.cpu_wait_n, 1);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h5A;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        reset = 1'b0;
        set_bus(K_NONE, 16'h0000, 8'h00);
        di_model = IDLE_DATA;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'h66;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("rst.after_req", bus.mem_req, 0);
        check("rst.after_wait", bus.cpu_wait_n, 1);
        check("rst.after_di", bus.cpu_di, IDLE_DATA);
        $display("[TB] reset_mid_req di=%h", bus.cpu_di);
    endtask

    initial begin
        reset = 1'b1;
        set_bus(K_NONE, 16'h0000, 8'h00);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        bus.io_ack    = 1'b0;
        bus.io_rdata  = 8'h00;
        di_model      = IDLE_DATA;
        repeat (3) @(negedge clk);

        check("reset.mem_req", bus.mem_req, 0);
        check("reset.io_req", bus.io_req, 0);
        check("reset.mem_we", bus.mem_we, 0);
        check("reset.io_we", bus.io_we, 0);
        check("reset.mem_addr", bus.mem_addr, 0);
        check("reset.mem_wdata", bus.mem_wdata, 0);
        check("reset.io_addr", bus.io_addr, 0);
        check("reset.io_wdata", bus.io_wdata, 0);
        check("reset.cpu_di", bus.cpu_di, IDLE_DATA);
        check("reset.wait_n", bus.cpu_wait_n, 1);

        set_bus(K_MRD, 16'hBEEF, 8'h11);
        @(negedge clk);
        check("reset.strobe_wait_n", bus.cpu_wait_n, 1);
        check("reset.strobe_req", bus.mem_req, 0);
        set_bus(K_NONE, 16'h0000, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        do_cycle(K_MRD,  16'h1234, 8'h00, 3, 8'hA5, "mem_read");
        do_cycle(K_MWR,  16'hC000, 8'h3C, 0, 8'h00, "mem_write");
        do_cycle(K_RFSH, 16'h007F, 8'h00, 0, 8'h00, "refresh");
        do_cycle(K_INTA, 16'h0000, 8'h00, 0, 8'h00, "intack");
        do_cycle(K_IORD, 16'h0040, 8'h00, 2, 8'h7E, "io_read");
        do_cycle(K_IOWR, 16'h1281, 8'h9C, 1, 8'h00, "io_write");
        do_cycle(K_BOTH, 16'h4321, 8'h00, 1, 8'h3D, "mixed_decode");
        reset_mid_req();
        do_cycle(K_MRD,  16'h8001, 8'h00, 0, 8'h42, "post_reset_read");

        for (int i = 0; i < 80; i++) begin
            do_cycle($urandom_range(0, 6), 16'($urandom), 8'($urandom),
                     $urandom_range(0, 5), 8'($urandom), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/z80_mem_bridge.md
Z80_MEM_BRIDGE -- requirements
Module: z80_mem_bridge

Interface
REQ-001 Parameter INTACK_VECTOR, default 8'hFF: byte returned on cpu_di during interrupt-acknowledge cycles.
REQ-002 Parameter IDLE_DATA, default 8'hFF: cpu_di value after reset and for unserviced reads.
REQ-003 clk  in  1  the single clock; every register updates on posedge clk.
REQ-004 reset  in  1  synchronous active-high reset, sampled on posedge clk.
REQ-005 cpu_a, cpu_dout, cpu_m1_n, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n  in  16/8/1/1/1/1/1  Z80 bus outputs; strobes change on negedge clk.
REQ-006 cpu_di  out  8  read data to CPU, registered; cpu_wait_n  out  1  Z80 WAIT, active low.
REQ-007 mem_req  out  1; mem_we  out  1; mem_addr  out  16; mem_wdata  out  8  memory request, held stable while mem_req=1.
REQ-008 mem_ack  in  1  one-cycle completion pulse; mem_rdata  in  8  read data, valid with mem_ack.
REQ-009 io_req, io_we  out  1 each; io_addr  out  8; io_wdata  out  8; io_ack  in  1; io_rdata  in  8  I/O port handshake, same rules as mem_*.

Function
REQ-010 States: IDLE, MEM, IO, HOLD; reset state IDLE.
REQ-011 Memory access = cpu_mreq_n=0 and (cpu_rd_n=0 or cpu_wr_n=0); refresh (cpu_mreq_n=0, cpu_rd_n=cpu_wr_n=1) is ignored.
REQ-012 I/O access = cpu_iorq_n=0, cpu_m1_n=1, and cpu_rd_n=0 or cpu_wr_n=0; interrupt ack = cpu_iorq_n=0 and cpu_m1_n=0.
REQ-013 IDLE + memory access: next edge -> MEM, mem_req=1, mem_we=~cpu_wr_n, mem_addr=cpu_a, mem_wdata=cpu_dout captured at that edge.
REQ-014 IDLE + I/O access: next edge -> IO, io_req=1, io_we=~cpu_wr_n, io_addr=cpu_a[7:0], io_wdata=cpu_dout.
REQ-015 IDLE + interrupt ack: next edge cpu_di=INTACK_VECTOR, -> HOLD, no request issued, cpu_wait_n stays 1.
REQ-016 cpu_wait_n is combinational: 0 when (state=IDLE and a memory/I/O access is decoded) or state in {MEM, IO}; else 1.
REQ-017 MEM: on mem_ack=1 -> HOLD, mem_req=0 same edge; if read, cpu_di=mem_rdata same edge; mem_ack while mem_req=0 ignored.
REQ-018 IO: identical with io_ack/io_rdata/io_req.
REQ-019 Ack in the first cycle of MEM/IO is legal: total wait = 1 cycle after strobe seen; no upper bound on ack latency.
REQ-020 HOLD: -> IDLE when cpu_rd_n=1 and cpu_wr_n=1; a strobe held across multiple cycles never issues a second request.
REQ-021 Writes leave cpu_di unchanged; cpu_di holds its value until next read completion or intack.
REQ-022 Simultaneous memory and I/O decode (illegal bus): memory wins.

Reset
REQ-023 reset=1: state=IDLE, mem_req=io_req=0, mem_we=io_we=0, addresses/wdata=0, cpu_di=IDLE_DATA; cpu_wait_n=1 while reset=1.
REQ-024 Reset mid-MEM/IO drops the request at that edge; a later ack is ignored; no pending state survives.

Configuration
REQ-025 Macro Z80_MEM_BRIDGE_IOPORT_EN defined: I/O accesses serviced per REQ-014/018, io_* ports live.
REQ-026 Macro absent: io_req, io_we, io_addr, io_wdata tied 0, io_ack/io_rdata unused; I/O reads load cpu_di=IDLE_DATA at next edge and go to HOLD, I/O writes go to HOLD directly; cpu_wait_n stays 1 for I/O cycles.

Verification
REQ-027 Memory read A=16'h1234, mem_ack 3 cycles after mem_req with mem_rdata=8'hA5 -> mem_addr=16'h1234, mem_we=0, cpu_wait_n low exactly 4 cycles, cpu_di=8'hA5, one request only.
REQ-028 Memory write A=16'hC000, dout=8'h3C, ack in first MEM cycle -> mem_we=1, mem_wdata=8'h3C, cpu_wait_n low 1 cycle, cpu_di unchanged.
REQ-029 Refresh cycle (mreq_n=0, rd_n=wr_n=1) then interrupt ack -> no mem_req, cpu_wait_n=1 throughout, cpu_di=8'hFF.
REQ-030 IOPORT_EN defined: I/O read port 8'h40, io_ack after 2 cycles, io_rdata=8'h7E -> io_addr=8'h40, cpu_di=8'h7E; undefined: cpu_di=8'hFF, io_req never 1, cpu_wait_n=1.
REQ-031 reset asserted 1 cycle after mem_req rises, mem_ack pulsed during reset -> mem_req=0, cpu_wait_n=1, cpu_di=8'hFF, state IDLE after release.
